output_crossfader: RTL and testbench

Click-free source selector and gain stage for the speaker path. It takes up to NUM_SRC 16-bit signed audio streams and selects one with src_sel. On every selection change it ramps the envelope down, swaps the source, and ramps back up. It applies a master gain, saturates the result to 16 bits, and drives level_in of the system pdm instance. Replaces the combinational sw[4..9] priority mux in front of the pdm.

---
 rtl/output_crossfader.sv | 163 ++++++++++++++++
 tb/tb_output_crossfader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/output_crossfader.sv
// Click-free source selector for the speaker path: fades out, swaps source, fades in,
// then applies master gain and saturates to 16 bits for the pdm level input.
module output_crossfader #(
  parameter int NUM_SRC   = 6,
  parameter int RAMP_LOG2 = 6
) (
  input  logic               audio_clk,
  input  logic               rst_in,
  input  logic               audio_trigger,
  input  logic signed [15:0] audio_in [NUM_SRC],
  input  logic [2:0]         src_sel,
  input  logic               mute_in,
  input  logic [7:0]         gain_in,
  input  logic               clip_clear,
  output logic signed [15:0] level_out,
  output logic               level_valid,
  output logic               busy,
  output logic               clip_out
);

  localparam int DATA_W  = 16;
  localparam int COEF_W  = 8;
  localparam int STAGES  = 2;
  localparam int EW      = RAMP_LOG2 + 1;
  localparam int P1W     = 18;
  localparam int PROD1_W = DATA_W + COEF_W + 1;
  localparam int PROD2_W = P1W + EW + 1;

  localparam logic [EW-1:0] ENV_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [EW-1:0] ENV_ONE  = {{RAMP_LOG2{1'b0}}, 1'b1};
  localparam logic [2:0]    SEL_MAX  = 3'(NUM_SRC);

  localparam logic signed [PROD2_W-1:0] SAT_HI = PROD2_W'(32767);
  localparam logic signed [PROD2_W-1:0] SAT_LO = PROD2_W'(-32768);

  typedef enum logic [1:0] {PLAY, FADE_OUT, SWAP, FADE_IN} state_t;

  // Returns {clipped, saturated sample}.
  function automatic logic [DATA_W:0] sat16(input logic signed [PROD2_W-1:0] v);
    if (v > SAT_HI)      sat16 = {1'b1, 16'h7fff};
    else if (v < SAT_LO) sat16 = {1'b1, 16'h8000};
    else                 sat16 = {1'b0, v[DATA_W-1:0]};
  endfunction

  state_t                     state_q, state_d;
  logic [EW-1:0]              env_q, env_d;
  logic [2:0]                 active_q, active_d;
  logic                       busy_q, busy_d;
  logic [2:0]                 target;
  logic signed [DATA_W-1:0]   x_sel;

  logic signed [DATA_W-1:0]   x_p0_q, x_p0_d;
  logic [EW-1:0]              e_p0_q, e_p0_d;
  logic [COEF_W-1:0]          g_p0_q, g_p0_d;
  logic                       vld_p0_q, vld_p0_d;

  logic signed [PROD1_W-1:0]  prod1;
  logic signed [P1W-1:0]      p1;
  logic signed [PROD2_W-1:0]  prod2;
  logic signed [PROD2_W-1:0]  p2;
  logic [DATA_W:0]            sat_res;

  logic signed [DATA_W-1:0]   level_p1_q, level_p1_d;
  logic                       vld_p1_q, vld_p1_d;
  logic                       clip_q, clip_d;

  always_comb begin
    target = 3'd0;
    if (!mute_in && src_sel <= SEL_MAX) target = src_sel;

    x_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (active_q == 3'(k + 1)) x_sel = audio_in[k];
    end

    state_d  = state_q;
    env_d    = env_q;
    active_d = active_q;
    if (audio_trigger) begin
      case (state_q)
        PLAY: begin
          if (target != active_q) state_d = FADE_OUT;
        end
        FADE_OUT: begin
          // env can be 0 here when a fade-in reverses right after a swap.
          if (env_q <= ENV_ONE) begin
            env_d   = '0;
            state_d = SWAP;
          end else begin
            env_d = env_q - ENV_ONE;
          end
        end
        SWAP: begin
          active_d = target;
          state_d  = FADE_IN;
        end
        FADE_IN: begin
          if (target != active_q) begin
            state_d = FADE_OUT;
          end else begin
            env_d = env_q + ENV_ONE;
            if (env_q == ENV_FULL - ENV_ONE) state_d = PLAY;
          end
        end
      endcase
    end
    busy_d = (state_d != PLAY);

    // Stage 0: capture pre-update source sample, envelope and gain.
    x_p0_d   = audio_trigger ? x_sel   : x_p0_q;
    e_p0_d   = audio_trigger ? env_q   : e_p0_q;
    g_p0_d   = audio_trigger ? gain_in : g_p0_q;
    vld_p0_d = audio_trigger;

    // Stage 1/2: gain, envelope scaling and saturation, registered once.
    prod1   = PROD1_W'(x_p0_q) * PROD1_W'($signed({1'b0, g_p0_q}));
    p1      = P1W'(prod1 >>> 6);
    prod2   = PROD2_W'(p1) * PROD2_W'($signed({1'b0, e_p0_q}));
    p2      = prod2 >>> RAMP_LOG2;
    sat_res = sat16(p2);

    level_p1_d = vld_p0_q ? $signed(sat_res[DATA_W-1:0]) : level_p1_q;
    vld_p1_d   = vld_p0_q;

    clip_d = clip_q;
    if (clip_clear) clip_d = 1'b0;
    if (vld_p0_q && sat_res[DATA_W]) clip_d = 1'b1;
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q    <= FADE_IN;
      env_q      <= '0;
      active_q   <= '0;
      busy_q     <= 1'b1;
      x_p0_q     <= '0;
      e_p0_q     <= '0;
      g_p0_q     <= '0;
      vld_p0_q   <= 1'b0;
      level_p1_q <= '0;
      vld_p1_q   <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      env_q      <= env_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
      x_p0_q     <= x_p0_d;
      e_p0_q     <= e_p0_d;
      g_p0_q     <= g_p0_d;
      vld_p0_q   <= vld_p0_d;
      level_p1_q <= level_p1_d;
      vld_p1_q   <= vld_p1_d;
      clip_q     <= clip_d;
    end
  end

  assign level_out   = level_p1_q;
  assign level_valid = vld_p1_q;
  assign busy        = busy_q;
  assign clip_out    = clip_q;

endmodule

// File: tb/tb_output_crossfader.sv
// Directed bench for output_crossfader with a 4-sample ramp (RAMP_LOG2 = 2).
module tb_output_crossfader;

  logic               clk;
  logic               rst;
  logic               trig;
  logic signed [15:0] ain [6];
  logic [2:0]         src_sel;
  logic               mute;
  logic [7:0]         gain;
  logic               clip_clear;
  logic signed [15:0] level_out;
  logic               level_valid;
  logic               busy;
  logic               clip_out;

  int checks = 0;
  int errors = 0;

  int seq_in   [11] = '{0, 0, 0, 0, 0, 0, 0, 250, 500, 750, 1000};
  int seq_sw   [11] = '{1000, 1000, 750, 500, 250, 0, 0, -500, -1000, -1500, -2000};
  int busy_sw  [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int seq_r1   [8]  = '{-2000, -2000, -1500, -1000, -500, 0, 0, 100};
  int seq_r2   [9]  = '{200, 200, 100, 0, 0, 200, 400, 600, 800};
  int seq_mute [10] = '{800, 800, 600, 400, 200, 0, 0, 0, 0, 0};

  output_crossfader #(.NUM_SRC(6), .RAMP_LOG2(2)) dut (
    .audio_clk    (clk),
    .rst_in       (rst),
    .audio_trigger(trig),
    .audio_in     (ain),
    .src_sel      (src_sel),
    .mute_in      (mute),
    .gain_in      (gain),
    .clip_clear   (clip_clear),
    .level_out    (level_out),
    .level_valid  (level_valid),
    .busy         (busy),
    .clip_out     (clip_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One trigger, then watch the two following cycles and one idle cycle.
  task automatic do_sample(output logic signed [15:0] lvl, output logic bsy,
                           output logic vmid, output logic vout, output logic vafter);
    @(posedge clk); #1;
    trig = 1'b1;
    bsy  = busy;
    @(posedge clk); #1;
    trig = 1'b0;
    vmid = level_valid;
    @(posedge clk); #1;
    vout = level_valid;
    lvl  = level_out;
    @(posedge clk); #1;
    vafter = level_valid;
  endtask

  task automatic expect_sample(input string tag, input int exp_lvl, input int exp_busy);
    logic signed [15:0] lvl;
    logic bsy, vm, vo, va;
    do_sample(lvl, bsy, vm, vo, va);
    chk({tag, "_vmid"}, vm, 0);
    chk({tag, "_valid"}, vo, 1);
    chk({tag, "_vafter"}, va, 0);
    chk({tag, "_lvl"}, lvl, exp_lvl);
    if (exp_busy >= 0) chk({tag, "_busy"}, bsy, exp_busy);
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; src_sel = 3'd0; mute = 1'b0; gain = 8'd64; clip_clear = 1'b0;
    for (int i = 0; i < 6; i++) ain[i] = 16'sd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_level", level_out, 0);
    chk("rst_valid", level_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_clip", clip_out, 0);

    for (int i = 0; i < 4; i++) expect_sample($sformatf("ramp%0d", i), 0, 1);
    chk("ramp_busy_done", busy, 0);
    chk("ramp_clip", clip_out, 0);

    ain[0] = 16'sd1000; ain[1] = -16'sd2000; ain[2] = 16'sd400; ain[3] = 16'sd800;
    src_sel = 3'd1;
    for (int i = 0; i < 11; i++) expect_sample($sformatf("in%0d", i), seq_in[i], busy_sw[i]);

    src_sel = 3'd2;
    for (int i = 0; i < 11; i++) expect_sample($sformatf("sw%0d", i), seq_sw[i], busy_sw[i]);

    src_sel = 3'd3;
    for (int i = 0; i < 8; i++) expect_sample($sformatf("rev_a%0d", i), seq_r1[i], (i == 0) ? 0 : 1);
    src_sel = 3'd4;
    for (int i = 0; i < 9; i++) expect_sample($sformatf("rev_b%0d", i), seq_r2[i], (i == 8) ? 0 : 1);

    mute = 1'b1;
    for (int i = 0; i < 10; i++) expect_sample($sformatf("mute%0d", i), seq_mute[i], (i == 0) ? 0 : 1);
    src_sel = 3'd0;
    expect_sample("muted_a", 0, 0);
    expect_sample("muted_b", 0, 0);
    chk("muted_busy", busy, 0);
    mute = 1'b0;
    src_sel = 3'd1;
    for (int i = 0; i < 11; i++) expect_sample($sformatf("unmute%0d", i), seq_in[i], busy_sw[i]);

    gain = 8'd255; ain[0] = 16'sd32767;
    expect_sample("clip_hi", 32767, 0);
    chk("clip_hi_flag", clip_out, 1);
    ain[0] = -16'sd32768;
    expect_sample("clip_lo", -32768, 0);
    chk("clip_lo_flag", clip_out, 1);
    @(posedge clk); #1 clip_clear = 1'b1;
    @(posedge clk); #1 clip_clear = 1'b0;
    chk("clip_cleared", clip_out, 0);
    gain = 8'd64; ain[0] = 16'sd1000;
    expect_sample("unity", 1000, 0);
    chk("unity_clip", clip_out, 0);
    ain[0] = 16'sd32767;
    expect_sample("edge_max", 32767, 0);
    chk("edge_max_clip", clip_out, 0);

    src_sel = 3'd2;
    expect_sample("pre_rst", 32767, 0);
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_valid", level_valid, 0);
    chk("midrst_level", level_out, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_clip", clip_out, 0);
    src_sel = 3'd0;
    for (int i = 0; i < 4; i++) expect_sample($sformatf("reramp%0d", i), 0, 1);
    chk("reramp_busy_done", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
